// File: rtl/binary_octal_decoder_seq_pkg.sv
// Shared types and helpers for the binary-to-octal pulse decoder.
//   state_t  : controller state encoding (2 bits)
//   CODE_W   : width of the binary code input (fixed at 3)
//   OUT_W    : width of the one-hot output (fixed at 8)
//   onehot8  : maps a 3-bit code to its one-hot line
package binary_octal_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [OUT_W-1:0] onehot8(input logic [CODE_W-1:0] code);
    logic [OUT_W-1:0] r;
    r = '0;
    r[code] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/binary_octal_decoder_seq_if.sv
// Handshake and data bundle for binary_octal_decoder_seq.
//   en, in_valid, in, hold : driven by the code source (master)
//   in_ready, out, busy, done : driven by the decoder (slave)
interface binary_octal_decoder_seq_if #(
  parameter int HOLD_W = 4
);
  import binary_octal_pkg::*;

  logic              en;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in;
  logic [HOLD_W-1:0] hold;
  logic [OUT_W-1:0]  out;
  logic              busy;
  logic              done;

  modport master (
    output en, in_valid, in, hold,
    input  in_ready, out, busy, done
  );

  modport slave (
    input  en, in_valid, in, hold,
    output in_ready, out, busy, done
  );

endinterface

// File: rtl/binary_octal_decoder_seq_counter.sv
// dec_down_counter: loadable down-counter with a zero flag.
//   clk, rst  : clock and synchronous active-high reset
//   clr       : synchronous clear (abort path)
//   load      : load load_val (takes priority over dec)
//   dec       : decrement by one, saturating at zero
//   zero      : count is zero
module dec_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/binary_octal_decoder_seq.sv
// Sequential 3-to-8 decoder: accepts a code over valid/ready, drives the
// matching one-hot line for a programmable number of cycles, then inserts
// GAP_CYCLES all-zero cycles before the next code can be accepted.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of binary_octal_decoder_seq_if
//              (en, in_valid, in, hold in; in_ready, out, busy, done out)
//
// state | meaning
// IDLE  | out=0, ready for a code when enabled
// DRIVE | out holds the one-hot code for the effective hold count
// GAP   | out=0, not ready, waits GAP_CYCLES cycles
module binary_octal_decoder_seq
  import binary_octal_pkg::*;
#(
  parameter int HOLD_W     = 4,
  parameter int GAP_CYCLES = 1
) (
  input logic                      clk,
  input logic                      rst,
  binary_octal_decoder_seq_if.slave bus
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  // Counters are loaded with (length - 1) and the phase ends on the zero
  // flag, so the zero flag marks the last cycle of each phase.
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_t            state_q, state_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              done_q, done_d;
  logic [CODE_W-1:0] code_q, code_d;

  logic              accept;
  logic [HOLD_W-1:0] hold_load_val;
  logic              hold_load, hold_dec, hold_zero;
  logic              gap_load, gap_dec, gap_zero;
  logic              cnt_clr;

  assign bus.in_ready = (state_q == IDLE) && bus.en && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  // hold==0 behaves as hold==1, i.e. a load value of zero.
  assign hold_load_val = (bus.hold == '0) ? '0 : bus.hold - HOLD_W'(1);

  dec_down_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (hold_load),
    .load_val (hold_load_val),
    .dec      (hold_dec),
    .zero     (hold_zero)
  );

  dec_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    done_d    = 1'b0;
    code_d    = code_q;
    hold_load = 1'b0;
    hold_dec  = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    cnt_clr   = 1'b0;

    case (state_q)
      IDLE: begin
        out_d = '0;
        if (accept) begin
          code_d    = bus.in;
          hold_load = 1'b1;
          out_d     = onehot8(bus.in);
          state_d   = DRIVE;
        end
      end

      DRIVE: begin
        if (!bus.en) begin
          out_d   = '0;
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (hold_zero) begin
          out_d  = '0;
          done_d = 1'b1;
          if (GAP_CYCLES > 0) begin
            gap_load = 1'b1;
            state_d  = GAP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          out_d    = onehot8(code_q);
          hold_dec = 1'b1;
        end
      end

      GAP: begin
        out_d = '0;
        if (!bus.en) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (gap_zero) begin
          state_d = IDLE;
        end else begin
          gap_dec = 1'b1;
        end
      end

      default: begin
        out_d   = '0;
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      done_q  <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      done_q  <= done_d;
      code_q  <= code_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_binary_octal_decoder_seq.sv
module tb_binary_octal_decoder_seq;

  localparam int HOLD_W = 4;
  localparam int GAP    = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  binary_octal_decoder_seq_if #(.HOLD_W(HOLD_W)) bus ();

  binary_octal_decoder_seq #(
    .HOLD_W     (HOLD_W),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference model: remaining cycles of drive and gap, plus last code.
  int         m_left = 0;
  int         m_gap  = 0;
  logic [2:0] m_code = '0;
  logic       m_done = 1'b0;

  function automatic logic [7:0] m_out();
    return (m_left > 0) ? (8'd1 << m_code) : 8'd0;
  endfunction

  function automatic logic m_busy();
    return (m_left > 0) || (m_gap > 0);
  endfunction

  task automatic model_update();
    if (rst) begin
      m_left = 0; m_gap = 0; m_code = '0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (!bus.en) begin
          m_left = 0; m_gap = 0;
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_done = 1'b1;
            m_gap  = GAP;
          end
        end
      end else if (m_gap > 0) begin
        if (!bus.en) m_gap = 0;
        else m_gap = m_gap - 1;
      end else if (bus.en && bus.in_valid) begin
        m_code = bus.in;
        m_left = (bus.hold == 0) ? 1 : int'(bus.hold);
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("model.out", bus.out, m_out());
    check("model.busy", {7'd0, bus.busy}, {7'd0, m_busy()});
    check("model.done", {7'd0, bus.done}, {7'd0, m_done});
    check("model.in_ready", {7'd0, bus.in_ready}, {7'd0, !m_busy() && bus.en && !rst});
    check("onehot", {7'd0, ($countones(bus.out) <= 1)}, 8'd1);
  endtask

  task automatic expect_now(input string name, input logic [7:0] o, input logic b,
                            input logic d, input logic r);
    check({name, ".out"}, bus.out, o);
    check({name, ".busy"}, {7'd0, bus.busy}, {7'd0, b});
    check({name, ".done"}, {7'd0, bus.done}, {7'd0, d});
    check({name, ".in_ready"}, {7'd0, bus.in_ready}, {7'd0, r});
  endtask

  typedef struct {
    logic [2:0] code;
    logic [3:0] hold;
    logic [7:0] exp_out;
    int         exp_len;
  } vec_t;

  vec_t tbl[12];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    logic acc;

    tbl[0]  = '{3'd0, 4'd1,  8'h01, 1};
    tbl[1]  = '{3'd1, 4'd1,  8'h02, 1};
    tbl[2]  = '{3'd2, 4'd1,  8'h04, 1};
    tbl[3]  = '{3'd3, 4'd1,  8'h08, 1};
    tbl[4]  = '{3'd4, 4'd1,  8'h10, 1};
    tbl[5]  = '{3'd5, 4'd1,  8'h20, 1};
    tbl[6]  = '{3'd6, 4'd1,  8'h40, 1};
    tbl[7]  = '{3'd7, 4'd1,  8'h80, 1};
    tbl[8]  = '{3'd7, 4'd0,  8'h80, 1};
    tbl[9]  = '{3'd2, 4'd5,  8'h04, 5};
    tbl[10] = '{3'd6, 4'd15, 8'h40, 15};
    tbl[11] = '{3'd1, 4'd3,  8'h02, 3};

    // Reset held with valid asserted
    bus.en = 1'b1; bus.in_valid = 1'b1; bus.in = 3'd3; bus.hold = 4'd2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_now("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0; bus.in_valid = 1'b0;
    tick();
    expect_now("post_reset", 8'h00, 1'b0, 1'b0, 1'b1);

    // Single pulse, code 3, hold 2, then gap
    bus.in = 3'd3; bus.hold = 4'd2; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.hold = 4'd9;
    expect_now("single.d1", 8'h08, 1'b1, 1'b0, 1'b0);
    tick();
    expect_now("single.d2", 8'h08, 1'b1, 1'b0, 1'b0);
    tick();
    expect_now("single.done", 8'h00, 1'b1, 1'b1, 1'b0);
    tick();
    expect_now("single.idle", 8'h00, 1'b0, 1'b0, 1'b1);

    // Table of codes and hold lengths
    for (int i = 0; i < 12; i++) begin
      bus.in = tbl[i].code; bus.hold = tbl[i].hold; bus.in_valid = 1'b1;
      acc = 1'b0;
      for (int w = 0; w < 10 && !acc; w++) begin
        acc = !m_busy() && bus.en;
        tick();
      end
      check("tbl.accept", {7'd0, acc}, 8'd1);
      bus.in_valid = 1'b0;
      len = 0;
      while (bus.out == tbl[i].exp_out && len < 20) begin
        len++;
        tick();
      end
      check("tbl.len", 8'(len), 8'(tbl[i].exp_len));
      check("tbl.done", {7'd0, bus.done}, 8'd1);
      check("tbl.out_low", bus.out, 8'h00);
    end
    tick();

    // Abort: code 5, hold 10, drop en in 4th drive cycle
    bus.in = 3'd5; bus.hold = 4'd10; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    expect_now("abort.d1", 8'h20, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    expect_now("abort.d4", 8'h20, 1'b1, 1'b0, 1'b0);
    bus.en = 1'b0;
    tick();
    expect_now("abort.off", 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("abort.no_done", {7'd0, bus.done}, 8'd0);
    end
    bus.en = 1'b1;
    tick();

    // Reset during drive, then a normal pulse
    bus.in = 3'd6; bus.hold = 4'd8; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    expect_now("mrst.d3", 8'h40, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    expect_now("mrst.rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    bus.in = 3'd1; bus.hold = 4'd3; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_now("mrst.new", 8'h02, 1'b1, 1'b0, 1'b0);
      tick();
    end
    expect_now("mrst.done", 8'h00, 1'b1, 1'b1, 1'b0);
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst          = ($urandom_range(0, 63) == 0);
      bus.en       = ($urandom_range(0, 19) != 0);
      bus.in_valid = $urandom_range(0, 1) != 0;
      bus.in       = 3'($urandom_range(0, 7));
      bus.hold     = 4'($urandom_range(0, 15));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
